// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: op codes, FSM states and byte-count/extension helpers shared with the RAM arbiter.
package mem_lsu_pkg;
    localparam int ALU_OP_W   = 8;
    localparam int REG_ADDR_W = 5;
    localparam logic [ALU_OP_W-1:0] OP_NOP = 8'h00;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 8'h20;
    localparam logic [ALU_OP_W-1:0] OP_LB  = 8'hE0;
    localparam logic [ALU_OP_W-1:0] OP_LH  = 8'hE1;
    localparam logic [ALU_OP_W-1:0] OP_LW  = 8'hE3;
    localparam logic [ALU_OP_W-1:0] OP_LBU = 8'hE4;
    localparam logic [ALU_OP_W-1:0] OP_LHU = 8'hE5;
    localparam logic [ALU_OP_W-1:0] OP_SB  = 8'hE8;
    localparam logic [ALU_OP_W-1:0] OP_SH  = 8'hE9;
    localparam logic [ALU_OP_W-1:0] OP_SW  = 8'hEB;
    typedef enum logic [1:0] {
        MemIdle   = 2'd0,
        MemAccess = 2'd1,
        MemDone   = 2'd2
    } mem_state_e;
    function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic logic [1:0] mem_len(input logic [ALU_OP_W-1:0] op);
        return (op inside {OP_LW, OP_SW}) ? 2'd3 : (op inside {OP_LH, OP_LHU, OP_SH}) ? 2'd1 : 2'd0;
    endfunction
    function automatic logic [31:0] load_ext(input logic [ALU_OP_W-1:0] op, input logic [31:0] data);
        return (op == OP_LB)  ? {{24{data[7]}}, data[7:0]} :
               (op == OP_LBU) ? {24'd0, data[7:0]} :
               (op == OP_LH)  ? {{16{data[15]}}, data[15:0]} :
               (op == OP_LHU) ? {16'd0, data[15:0]} : data;
    endfunction
endpackage

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage moving loads/stores one byte per granted cycle over a byte-wide RAM port.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o,
    output logic                  stallreq_o,
    output logic                  ram_req_o,
    output logic                  ram_wr_o,
    output logic [31:0]           ram_addr_o,
    output logic [7:0]            ram_wdata_o,
    input  logic [7:0]            ram_rdata_i,
    input  logic                  ram_ready_i
);
    mem_state_e            state_q, state_d;
    logic [ALU_OP_W-1:0]   op_q, op_d;
    logic [31:0]           addr_q, addr_d, sdata_q, sdata_d, buf_q, buf_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [1:0]            cnt_q, cnt_d, len_q, len_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MemIdle;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            buf_q   <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            buf_q   <= buf_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        buf_d       = buf_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stallreq_o  = 1'b0;
        ram_req_o   = 1'b0;
        ram_wr_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        case (state_q)
            MemIdle: begin
                if (is_load(aluop_i) || is_store(aluop_i)) begin
                    stallreq_o = 1'b1;
                    state_d    = MemAccess;
                    op_d       = aluop_i;
                    addr_d     = mem_addr_i;
                    sdata_d    = reg2_i;
                    wd_d       = wd_i;
                    wreg_d     = wreg_i;
                    cnt_d      = '0;
                    len_d      = mem_len(aluop_i);
                    buf_d      = '0;
                end else begin
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end
            end
            MemAccess: begin
                stallreq_o  = 1'b1;
                ram_req_o   = 1'b1;
                ram_wr_o    = is_store(op_q);
                ram_addr_o  = addr_q + {30'd0, cnt_q};
                ram_wdata_o = sdata_q[{cnt_q, 3'b000} +: 8];
                if (ram_ready_i) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = is_load(op_q) ? ram_rdata_i : buf_q[{cnt_q, 3'b000} +: 8];
                    state_d = (cnt_q == len_q) ? MemDone : MemAccess;
                    cnt_d   = (cnt_q == len_q) ? cnt_q : cnt_q + 2'd1;
                end
            end
            MemDone: begin
                state_d = MemIdle;
                wd_o    = is_load(op_q) ? wd_q : '0;
                wreg_o  = is_load(op_q) && wreg_q;
                wdata_o = is_load(op_q) ? load_ext(op_q, buf_q) : '0;
            end
            default: state_d = MemIdle;
        endcase
        // Reset forces every output low, even while the registers still hold an access.
        if (rst) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = '0;
            stallreq_o  = 1'b0;
            ram_req_o   = 1'b0;
            ram_wr_o    = 1'b0;
            ram_addr_o  = '0;
            ram_wdata_o = '0;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with a 256-byte RAM model aliased on the low address byte.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  data;
    } xfer_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ALU_OP_W-1:0]   aluop_i;
    logic [31:0]           mem_addr_i, reg2_i, wdata_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [31:0]           wdata_o;
    logic                  stallreq_o, ram_req_o, ram_wr_o;
    logic [31:0]           ram_addr_o;
    logic [7:0]            ram_wdata_o, ram_rdata_i;
    logic                  ram_ready_i;

    xfer_t exp_q[$];
    xfer_t got_q[$];
    logic [7:0] ram [0:255];
    int passed = 0;
    int total = 0;
    int cyc_idx = 0;
    logic                  s_stall, s_req, s_wreg;
    logic [REG_ADDR_W-1:0] s_wd;
    logic [31:0]           s_wdata;

    mem_lsu dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stallreq_o(stallreq_o), .ram_req_o(ram_req_o), .ram_wr_o(ram_wr_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .ram_ready_i(ram_ready_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        ram_rdata_i = ram[ram_addr_o[7:0]];
        #1;
        s_stall = stallreq_o;
        s_req   = ram_req_o;
        s_wd    = wd_o;
        s_wreg  = wreg_o;
        s_wdata = wdata_o;
        if (ram_req_o && ram_ready_i) begin
            got_q.push_back('{cyc_idx, ram_addr_o, ram_wr_o, ram_wr_o ? ram_wdata_o : ram_rdata_i});
            if (ram_wr_o) ram[ram_addr_o[7:0]] = ram_wdata_o;
        end
        cyc_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] wd, input logic wreg);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = data;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = 32'hCAFE_0000;
    endtask

    task automatic run(input int wait_n, output int n);
        int wc;
        wc = 0;
        n = 0;
        cyc_idx = 0;
        do begin
            ram_ready_i = (wc >= wait_n);
            tick();
            wc = (!s_req || ram_ready_i) ? 0 : wc + 1;
            n++;
        end while (s_stall && n < 40);
        aluop_i = OP_NOP;
        wd_i    = '0;
        wreg_i  = 1'b0;
        wdata_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        aluop_i = OP_ADD; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        tick();
        total++; if (s_stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", s_stall); else passed++;
        total++; if (s_req !== 1'b0) $display("FAIL reset_req got=%b want=0", s_req); else passed++;
        total++; if ({s_wd, s_wreg, s_wdata} !== '0) $display("FAIL reset_wb got wd=%0d wreg=%b wdata=%h want all 0", s_wd, s_wreg, s_wdata); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        issue(OP_ADD, 32'h0, 32'h0, 5'd5, 1'b1);
        wdata_i = 32'h1234_5678;
        tick();
        total++; if (s_wd !== 5'd5 || s_wreg !== 1'b1) $display("FAIL pass_wd got wd=%0d wreg=%b want 5/1", s_wd, s_wreg); else passed++;
        total++; if (s_wdata !== 32'h1234_5678) $display("FAIL pass_wdata got=%h want=12345678", s_wdata); else passed++;
        total++; if (s_stall !== 1'b0 || s_req !== 1'b0) $display("FAIL pass_stall got stall=%b req=%b want 0/0", s_stall, s_req); else passed++;
        aluop_i = OP_NOP;
    endtask

    task automatic test_lw();
        int n;
        logic [7:0] b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        for (int i = 0; i < 4; i++) begin
            ram[i] = b[i];
            exp_q.push_back('{i + 1, 32'h100 + 32'(i), 1'b0, b[i]});
        end
        got_q.delete();
        issue(OP_LW, 32'h100, 32'h0, 5'd9, 1'b1);
        run(0, n);
        total++; if (n !== 6) $display("FAIL lw_cycles got=%0d want=6", n); else passed++;
        total++; if (s_wdata !== 32'h1234_5678) $display("FAIL lw_wdata got=%h want=12345678", s_wdata); else passed++;
        total++; if (s_wd !== 5'd9 || s_wreg !== 1'b1) $display("FAIL lw_wd got wd=%0d wreg=%b want 9/1", s_wd, s_wreg); else passed++;
        while (exp_q.size() > 0) begin
            xfer_t e, g;
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) $display("FAIL lw_xfer missing, want addr=%h", e.addr);
            else begin
                g = got_q.pop_front();
                if (g.cyc != e.cyc || g.addr !== e.addr || g.wr !== e.wr || g.data !== e.data)
                    $display("FAIL lw_xfer got cyc=%0d addr=%h wr=%b data=%h want cyc=%0d addr=%h wr=%b data=%h",
                             g.cyc, g.addr, g.wr, g.data, e.cyc, e.addr, e.wr, e.data);
                else passed++;
            end
        end
        total++; if (got_q.size() != 0) $display("FAIL lw_extra got=%0d extra transfers want=0", got_q.size()); else passed++;
    endtask

    task automatic test_byte_half();
        int n;
        ram[8'h10] = 8'h80;
        ram[8'h20] = 8'h80;
        ram[8'h21] = 8'hFF;
        issue(OP_LB, 32'h210, 32'h0, 5'd1, 1'b1);
        run(0, n);
        total++; if (n !== 3 || s_wdata !== 32'hFFFF_FF80) $display("FAIL lb got n=%0d wdata=%h want 3/ffffff80", n, s_wdata); else passed++;
        issue(OP_LBU, 32'h210, 32'h0, 5'd1, 1'b1);
        run(0, n);
        total++; if (n !== 3 || s_wdata !== 32'h0000_0080) $display("FAIL lbu got n=%0d wdata=%h want 3/00000080", n, s_wdata); else passed++;
        issue(OP_LH, 32'h320, 32'h0, 5'd2, 1'b1);
        run(0, n);
        total++; if (n !== 4 || s_wdata !== 32'hFFFF_FF80) $display("FAIL lh got n=%0d wdata=%h want 4/ffffff80", n, s_wdata); else passed++;
        issue(OP_LHU, 32'h320, 32'h0, 5'd2, 1'b1);
        run(0, n);
        total++; if (n !== 4 || s_wdata !== 32'h0000_FF80) $display("FAIL lhu got n=%0d wdata=%h want 4/0000ff80", n, s_wdata); else passed++;
        got_q.delete();
    endtask

    task automatic test_sh_wait();
        int n;
        exp_q.push_back('{3, 32'hFFFF_FFFF, 1'b1, 8'hDD});
        exp_q.push_back('{6, 32'h0000_0000, 1'b1, 8'hCC});
        issue(OP_SH, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd7, 1'b1);
        run(2, n);
        ram_ready_i = 1'b1;
        total++; if (n !== 8) $display("FAIL sh_cycles got=%0d want=8", n); else passed++;
        total++; if ({s_wd, s_wreg, s_wdata} !== '0) $display("FAIL sh_wb got wd=%0d wreg=%b wdata=%h want all 0", s_wd, s_wreg, s_wdata); else passed++;
        while (exp_q.size() > 0) begin
            xfer_t e, g;
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) $display("FAIL sh_xfer missing, want addr=%h", e.addr);
            else begin
                g = got_q.pop_front();
                if (g.cyc != e.cyc || g.addr !== e.addr || g.wr !== e.wr || g.data !== e.data)
                    $display("FAIL sh_xfer got cyc=%0d addr=%h wr=%b data=%h want cyc=%0d addr=%h wr=%b data=%h",
                             g.cyc, g.addr, g.wr, g.data, e.cyc, e.addr, e.wr, e.data);
                else passed++;
            end
        end
        total++; if (got_q.size() != 0) $display("FAIL sh_extra got=%0d extra transfers want=0", got_q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) ram[8'h40 + i] = b[i];
        got_q.delete();
        ram_ready_i = 1'b1;
        cyc_idx = 0;
        issue(OP_LW, 32'h40, 32'h0, 5'd3, 1'b1);
        repeat (3) tick();
        total++; if (got_q.size() != 2 || got_q[0].addr !== 32'h40 || got_q[1].addr !== 32'h41)
            $display("FAIL rstmid_partial got %0d transfers want 2 at 40,41", got_q.size()); else passed++;
        rst = 1'b1;
        tick();
        total++; if ({s_stall, s_req, s_wd, s_wreg, s_wdata} !== '0)
            $display("FAIL rstmid_outputs got stall=%b req=%b wdata=%h want all 0", s_stall, s_req, s_wdata); else passed++;
        rst = 1'b0;
        aluop_i = OP_NOP; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        tick();
        total++; if ({s_stall, s_req, s_wdata} !== '0) $display("FAIL rstmid_idle got stall=%b req=%b wdata=%h want idle", s_stall, s_req, s_wdata); else passed++;
        got_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back('{i + 1, 32'h40 + 32'(i), 1'b0, b[i]});
        issue(OP_LW, 32'h40, 32'h0, 5'd3, 1'b1);
        run(0, n);
        total++; if (n !== 6 || s_wdata !== 32'h4433_2211) $display("FAIL rstmid_lw got n=%0d wdata=%h want 6/44332211", n, s_wdata); else passed++;
        while (exp_q.size() > 0) begin
            xfer_t e, g;
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) $display("FAIL rstmid_xfer missing, want addr=%h", e.addr);
            else begin
                g = got_q.pop_front();
                if (g.cyc != e.cyc || g.addr !== e.addr || g.wr !== e.wr || g.data !== e.data)
                    $display("FAIL rstmid_xfer got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                             g.cyc, g.addr, g.data, e.cyc, e.addr, e.data);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        got_q.delete();
        issue(OP_SB, 32'h80, 32'h1234_56A5, 5'd4, 1'b1);
        run(0, n1);
        issue(OP_LB, 32'h80, 32'h0, 5'd6, 1'b1);
        run(0, n2);
        total++; if (n1 + n2 !== 6) $display("FAIL b2b_cycles got=%0d want=6", n1 + n2); else passed++;
        total++; if (s_wdata !== 32'hFFFF_FFA5 || s_wd !== 5'd6) $display("FAIL b2b_lb got wdata=%h wd=%0d want ffffffa5/6", s_wdata, s_wd); else passed++;
        total++; if (got_q.size() != 2 || got_q[0].wr !== 1'b1 || got_q[0].data !== 8'hA5 || got_q[1].wr !== 1'b0)
            $display("FAIL b2b_xfers got %0d transfers want store A5 then load", got_q.size()); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        rst = 1'b1; aluop_i = OP_NOP; mem_addr_i = '0; reg2_i = '0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; ram_rdata_i = '0; ram_ready_i = 1'b1;
        test_reset();
        test_passthrough();
        test_lw();
        test_byte_half();
        test_sh_wait();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the RISC-V pipeline, directly downstream of execute through the EX/MEM latch. It consumes the ALU op, effective address and store data produced by execute. Loads and stores are performed over the single byte-wide RAM port, one byte per granted cycle, and the pipeline is held with a stall request until the access completes. Non-memory instructions pass through to MEM/WB unchanged with zero added latency.

## Interface
- No parameters; widths come from the shared `define.v` macros.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high (`RstEnable`).
- `aluop_i` in `AluOpBus`: op from EX/MEM; the memory ops are LB/LBU/LH/LHU/LW/SB/SH/SW.
- `mem_addr_i` in 32: effective byte address computed by execute.
- `reg2_i` in 32: store data.
- `wd_i` in `RegAddrBus`, `wreg_i` in 1, `wdata_i` in 32: write-back request from execute.
- `wd_o` out `RegAddrBus`, `wreg_o` out 1, `wdata_o` out 32: to MEM/WB and forwarding to decode.
- `stallreq_o` out 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `ram_req_o` out 1, `ram_wr_o` out 1, `ram_addr_o` out 32, `ram_wdata_o` out 8: byte request to the RAM port.
- `ram_rdata_i` in 8, `ram_ready_i` in 1: the byte is transferred on any cycle with `ram_req_o && ram_ready_i`; read data is valid in that same cycle.

## Operation
- States: IDLE, ACCESS, DONE. Registers:
  - `op_q`, `addr_q`, `sdata_q`, `wd_q`, `wreg_q`
  - `cnt_q` (2 bits, index of the byte in progress)
  - `len_q` (byte count minus 1: B=0, H=1, W=3)
  - `buf_q` (32 bits, assembled load data)
- IDLE, non-memory op:
  - Outputs are combinational copies of `wd_i`/`wreg_i`/`wdata_i`.
  - `stallreq_o=0`, `ram_req_o=0`.
- IDLE, memory op:
  - `stallreq_o=1`; outputs `wreg_o=0`, `wd_o=0`, `wdata_o=0`.
  - Latch all inputs, set `cnt_q=0`, clear `buf_q`, go to ACCESS.
- ACCESS:
  - `ram_req_o=1`, `ram_wr_o` = op is a store, `ram_addr_o=addr_q+cnt_q` (mod 2^32).
  - `ram_wdata_o=sdata_q[8*cnt_q+7 -: 8]` (little-endian).
  - `stallreq_o=1`; write-back outputs are zero.
- Transfer in ACCESS:
  - Loads: `buf_q[8*cnt_q+7 -: 8] <= ram_rdata_i`.
  - If `cnt_q==len_q` go to DONE, else `cnt_q+1`.
  - Without `ram_ready_i` the state holds and the request/address/data stay stable.
- DONE:
  - `stallreq_o=0`, `ram_req_o=0`; go to IDLE unconditionally.
  - Loads: `wd_o=wd_q`, `wreg_o=wreg_q`, `wdata_o`:
    - LB: `{{24{buf_q[7]}},buf_q[7:0]}`
    - LBU: zero-extended byte
    - LH/LHU: sign- or zero-extended from bit 15
    - LW: `buf_q`
  - Stores: `wreg_o=0`, `wd_o=0`, `wdata_o=0`.
- No alignment check; any address is legal because bytes are addressed individually.
- A memory op arriving in IDLE the cycle after DONE is treated as a new instruction; the EX/MEM latch has advanced because the stall dropped in DONE.

## Timing
- Reset (`rst=1` at an edge):
  - State becomes IDLE; all registers clear.
  - While `rst=1`, every output is 0, including `stallreq_o` and `ram_req_o`.
- Reset mid-ACCESS: the access is abandoned; bytes already written by a store stay written.
- Non-memory op: 0 added cycles.
- N-byte access with `ram_ready_i` held at 1:
  - cycle 0 IDLE (stall), cycles 1..N ACCESS, cycle N+1 DONE.
  - Occupancy is N+2 cycles: LB 3, LH 4, LW 6.
- Each cycle with `ram_ready_i=0` in ACCESS adds one cycle.
- `ram_req_o`, `ram_addr_o` and `ram_wdata_o` are functions of registered state only (no input-to-RAM-port combinational path).
- `stallreq_o` is combinational from state and `aluop_i`; it is the one intended input-to-output path.

## Structure
- State encodings (`MemIdle`, `MemAccess`, `MemDone`, 2 bits) go in `define.v`, alongside the existing op codes.
- The byte-count decode (op to `len`) is a `define.v`-level function or localparam set shared with the RAM arbiter.
- No sub-module: the FSM, byte steering and extension live in one module.

## Test plan
- Pass-through:
  - Stimulus: ADD op, `wd_i=5`, `wdata_i=0x12345678`.
  - Response: same cycle `wd_o=5`, `wdata_o=0x12345678`, `stallreq_o=0`, `ram_req_o=0`.
- LW, ready held 1:
  - Stimulus: addr `0x100`, RAM bytes 0x78,0x56,0x34,0x12.
  - Response: addresses `0x100..0x103` on cycles 1-4; DONE on cycle 5 with `wdata_o=0x12345678`; stall high on cycles 0-4.
- LB/LBU:
  - Stimulus: byte 0x80.
  - Response: LB gives `0xFFFFFF80`, LBU gives `0x00000080`.
  - Stimulus: LH of 0x80,0xFF.
  - Response: `0xFFFFFF80`.
- SH with wait states:
  - Stimulus: `reg2_i=0xAABBCCDD`, addr `0xFFFFFFFF`, `ram_ready_i` low 2 cycles per byte.
  - Response: writes 0xDD@`0xFFFFFFFF`, then 0xCC@`0x00000000` (wrap); `wreg_o=0` in DONE; 8 cycles total.
- Reset mid-LW:
  - Stimulus: assert `rst` after the 2nd byte.
  - Response: next cycle IDLE, all outputs 0; a following LW restarts at byte 0.
- Back-to-back:
  - Stimulus: SB then LB to the same address.
  - Response: the LB returns the stored byte; no cycle is lost beyond DONE→IDLE.
